// File: rtl/life_pkg.sv
// Shared types and Game of Life rule constants for the life_engine block.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_FINISH = 2'd2
    } life_state_t;

    localparam logic [3:0] BIRTH_N = 4'd3;
    localparam logic [3:0] SURV_LO = 4'd2;
    localparam logic [3:0] SURV_HI = 4'd3;

    function automatic logic cell_next(input logic alive, input logic [3:0] nbrs);
        if (alive) begin
            return (nbrs >= SURV_LO) && (nbrs <= SURV_HI);
        end
        return nbrs == BIRTH_N;
    endfunction

endpackage

// File: rtl/life_row.sv
// Combinational next-row generator; column wrap enabled by LIFE_WRAP_EN.
module life_row
    import life_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] above_i,
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] below_i,
    output logic [WIDTH-1:0] next_o
);

    // Rows extended by one column on each side; ext[c+1] is column c.
    logic [WIDTH+1:0] above_e;
    logic [WIDTH+1:0] cur_e;
    logic [WIDTH+1:0] below_e;

`ifdef LIFE_WRAP_EN
    assign above_e = {above_i[0], above_i, above_i[WIDTH-1]};
    assign cur_e   = {cur_i[0],   cur_i,   cur_i[WIDTH-1]};
    assign below_e = {below_i[0], below_i, below_i[WIDTH-1]};
`else
    assign above_e = {1'b0, above_i, 1'b0};
    assign cur_e   = {1'b0, cur_i,   1'b0};
    assign below_e = {1'b0, below_i, 1'b0};
`endif

    always_comb begin
        logic [3:0] nbrs;
        nbrs   = '0;
        next_o = '0;
        for (int c = 0; c < WIDTH; c++) begin
            nbrs = {3'b0, above_e[c]} + {3'b0, above_e[c+1]} + {3'b0, above_e[c+2]}
                 + {3'b0, cur_e[c]}                          + {3'b0, cur_e[c+2]}
                 + {3'b0, below_e[c]} + {3'b0, below_e[c+1]} + {3'b0, below_e[c+2]};
            next_o[c] = cell_next(cur_i[c], nbrs);
        end
    end

endmodule

// File: rtl/life_engine.sv
// Row-serial Conway Life engine over a HEIGHT x WIDTH board.
// Toroidal board when LIFE_WRAP_EN is defined, dead border otherwise.
module life_engine
    import life_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 8
) (
    input  logic                      ph1,
    input  logic                      reset_n,
    input  logic                      load_valid,
    input  logic [$clog2(HEIGHT)-1:0] load_row,
    input  logic [WIDTH-1:0]          load_data,
    output logic                      load_ready,
    input  logic                      start,
    input  logic [GEN_W-1:0]          gens,
    output logic                      busy,
    output logic                      done,
    output logic                      stable,
    output logic [GEN_W-1:0]          gen_count,
    input  logic [$clog2(HEIGHT)-1:0] rd_row,
    output logic [WIDTH-1:0]          rd_data
);

    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    life_state_t      state_q, state_d;
    logic [WIDTH-1:0] board_q [HEIGHT];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] row0_q;
    logic [ROW_W-1:0] row_q;
    logic [GEN_W-1:0] gens_left_q;
    logic [GEN_W-1:0] gen_count_q;
    logic             stable_q;
    logic             changed_q;

    logic [WIDTH-1:0] above_row;
    logic [WIDTH-1:0] cur_row;
    logic [WIDTH-1:0] below_row;
    logic [WIDTH-1:0] next_row;
    logic             gen_end;
    logic             gen_changed;

    // Rows above row_q are already rewritten, so the original previous row and
    // original row 0 come from the shadows; rows below are still untouched.
    always_comb begin
        cur_row = board_q[row_q];
        if (row_q == '0) begin
`ifdef LIFE_WRAP_EN
            above_row = board_q[LAST_ROW];
`else
            above_row = '0;
`endif
        end else begin
            above_row = prev_q;
        end
        if (row_q == LAST_ROW) begin
`ifdef LIFE_WRAP_EN
            below_row = row0_q;
`else
            below_row = '0;
`endif
        end else begin
            below_row = board_q[row_q + ROW_W'(1)];
        end
    end

    life_row #(.WIDTH(WIDTH)) u_row (
        .above_i (above_row),
        .cur_i   (cur_row),
        .below_i (below_row),
        .next_o  (next_row)
    );

    assign gen_end     = (state_q == ST_STEP) && (row_q == LAST_ROW);
    assign gen_changed = changed_q || (next_row != cur_row);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (gens == '0) ? ST_FINISH : ST_STEP;
                end
            end
            ST_STEP: begin
                if (gen_end && (!gen_changed || gens_left_q == GEN_W'(1))) begin
                    state_d = ST_FINISH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            for (int r = 0; r < HEIGHT; r++) begin
                board_q[r] <= '0;
            end
            prev_q      <= '0;
            row0_q      <= '0;
            row_q       <= '0;
            gens_left_q <= '0;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (load_valid && (int'(load_row) < HEIGHT)) begin
                        board_q[load_row] <= load_data;
                    end
                    if (start) begin
                        gens_left_q <= gens;
                        gen_count_q <= '0;
                        stable_q    <= 1'b0;
                        changed_q   <= 1'b0;
                        row_q       <= '0;
                    end
                end
                ST_STEP: begin
                    board_q[row_q] <= next_row;
                    prev_q         <= cur_row;
                    if (row_q == '0) begin
                        row0_q <= cur_row;
                    end
                    if (gen_end) begin
                        row_q       <= '0;
                        changed_q   <= 1'b0;
                        stable_q    <= !gen_changed;
                        gens_left_q <= gens_left_q - GEN_W'(1);
                        if (gen_count_q != '1) begin
                            gen_count_q <= gen_count_q + GEN_W'(1);
                        end
                    end else begin
                        row_q     <= row_q + ROW_W'(1);
                        changed_q <= gen_changed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign stable     = stable_q;
    assign gen_count  = gen_count_q;
    assign rd_data    = (int'(rd_row) < HEIGHT) ? board_q[rd_row] : '0;

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning cells per row (>=3).
REQ-002 SHALL have parameter HEIGHT, default 8, meaning rows per board (>=3).
REQ-003 SHALL have parameter GEN_W, default 8, meaning width of the generation-request and generation-counter fields.
REQ-004 SHALL have port ph1  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port load_valid  in  1  writes load_data into row load_row this cycle.
REQ-007 SHALL have port load_row  in  $clog2(HEIGHT)  target row for a load.
REQ-008 SHALL have port load_data  in  WIDTH  row contents; bit i is column i, 1 = alive.
REQ-009 SHALL have port load_ready  out  1  high when loads are accepted, i.e. in IDLE.
REQ-010 SHALL have port start  in  1  single-cycle request to run gens generations.
REQ-011 SHALL have port gens  in  GEN_W  number of generations to run; sampled on accepted start.
REQ-012 SHALL have port busy  out  1  high while a run is in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse when a run ends.
REQ-014 SHALL have port stable  out  1  last completed generation equalled its predecessor.
REQ-015 SHALL have port gen_count  out  GEN_W  generations completed in the current or last run.
REQ-016 SHALL have port rd_row  in  $clog2(HEIGHT)  display read row select.
REQ-017 SHALL have port rd_data  out  WIDTH  combinational contents of board row rd_row.

Function
REQ-018 SHALL hold the board in HEIGHT x WIDTH flops, with rd_data showing committed state and no mid-generation values exposed except rows already updated in the generation in progress.
REQ-019 SHALL implement states IDLE, STEP and FINISH: IDLE->STEP on start with gens!=0; IDLE->FINISH on start with gens==0; STEP->FINISH after the last row of the last generation or on early stop; FINISH->IDLE unconditionally.
REQ-020 SHALL update one row per cycle in STEP, in order from row 0 to row HEIGHT-1, so one generation takes exactly HEIGHT cycles.
REQ-021 SHALL compute each row from pre-generation data only, keeping original row 0 and the original previous row in shadow registers for row HEIGHT-1 and row r-1 references.
REQ-022 SHALL use B3/S23 rules: a dead cell with exactly 3 live neighbours is born; a live cell with 2 or 3 live neighbours survives; every other cell is dead.
REQ-023 SHALL count neighbours in a 4-bit sum (0..8) with no truncation.
REQ-024 SHALL increment gen_count at the end of each generation, set stable to (no cell changed in that generation), and enter FINISH early when stable is 1.
REQ-025 SHALL assert done for exactly the single FINISH cycle, with busy high in STEP and FINISH only.
REQ-026 SHALL clear gen_count and stable on an accepted start.
REQ-027 SHALL ignore start and load_valid when not in IDLE; in IDLE, start and load_valid asserted together SHALL apply the load first, so the run sees the loaded row.
REQ-028 SHALL saturate gen_count at its maximum value and never wrap it.

Reset
REQ-029 SHALL, on asserted reset_n at any time including mid-run, clear all board cells and shadow rows, set state to IDLE, and drive busy=0, done=0, stable=0, gen_count=0, load_ready=1.
REQ-030 SHALL accept the first start or load on the first rising ph1 edge after reset_n deasserts.

Configuration
REQ-031 SHALL, with LIFE_WRAP_EN defined, treat the board as a torus: column 0 neighbours column WIDTH-1 and row 0 neighbours row HEIGHT-1.
REQ-032 SHALL, without LIFE_WRAP_EN, treat every off-board neighbour as dead.

Structure
REQ-033 SHALL place state enum life_state_t and rule constants BIRTH_N=3, SURV_LO=2, SURV_HI=3 in package life_pkg.
REQ-034 SHALL use one combinational sub-module, life_row, that maps above, current and below rows of WIDTH bits to the next row, with wrap/no-wrap chosen by LIFE_WRAP_EN; it SHALL be instantiated once and time-shared across rows.

Verification
REQ-035 SHALL test a blinker: row 3 = 8'b0001_1100, start with gens=1 -> rows 2..4 = 8'b0000_1000, done after 9 cycles, gen_count=1, stable=0.
REQ-036 SHALL test a block: rows 1..2 = 8'b0000_0110, gens=5 -> board unchanged, stable=1, gen_count=1, early done.
REQ-037 SHALL test gens=0: start -> done on the next cycle, board unchanged, gen_count=0.
REQ-038 SHALL test wrap: a glider at the bottom-right corner with LIFE_WRAP_EN, gens=4 -> glider shifted by (+1,+1) modulo 8; without the macro -> cells clipped and matching a golden model.
REQ-039 SHALL test reset mid-run: reset_n pulsed low during STEP row 4 -> all rd_data=0, busy=0, load_ready=1 immediately.
REQ-040 SHALL test loads during a run: load_valid while busy -> board unaffected and load_ready=0.
